// File: rtl/idli_pkg.sv
// Shared types for the idli core datapath.
// Word, slice and counter types plus UART receiver states.
package idli_pkg;

  typedef logic [3:0]  slice_t;
  typedef logic [15:0] data_t;
  typedef logic [1:0]  ctr_t;

  typedef enum logic [1:0] {
    UART_RX_IDLE,
    UART_RX_START,
    UART_RX_DATA,
    UART_RX_STOP
  } uart_rx_state_t;

  localparam int unsigned UART_CLKS_PER_BIT = 16;

  function automatic slice_t slice_sel(
    input data_t d,
    input ctr_t  c
  );
    slice_t s;
    s = '0;
    unique case (1'b1)
      c == 2'd0: s = d[3:0];
      c == 2'd1: s = d[7:4];
      c == 2'd2: s = d[11:8];
      c == 2'd3: s = d[15:12];
      default:   s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/idli_sync_m.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// Reset value is a parameter so idle-high lines come up idle.
module idli_sync_m #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] ff_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ff_q <= {2{RST_VAL}};
    end else begin
      ff_q <= {ff_q[0], i_d};
    end
  end

  assign o_q = ff_q[1];

endmodule

// File: rtl/idli_uart_rx_m.sv
// UART 8N1 receiver feeding the SRC_UART operand path.
// Pairs bytes little-endian into a single buffered 16b word.
module idli_uart_rx_m
  import idli_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_uart_rx,
  input  ctr_t   i_ctr,
  input  logic   i_rd,
  output logic   o_valid,
  output slice_t o_slice,
  output logic   o_err,
  output logic   o_overrun
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef logic [CW-1:0] bctr_t;

  localparam bctr_t HALF = bctr_t'(CLKS_PER_BIT / 2 - 1);
  localparam bctr_t FULL = bctr_t'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_rx_state_t state_q, state_d;
  bctr_t          bit_ctr_q, bit_ctr_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     byte_q, byte_d;
  logic [7:0]     lo_q, lo_d;
  logic           hi_q, hi_d;
  data_t          buf_q, buf_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic           ovr_q, ovr_d;

  logic  ctr_zero;
  logic  stop_smp;
  logic  word_done;
  logic  pop;
  data_t word;

  idli_sync_m #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_uart_rx),
    .o_q     (rx_s)
  );

  assign ctr_zero = (bit_ctr_q == '0);

  always_comb begin
    state_d   = state_q;
    bit_ctr_d = bit_ctr_q;
    bit_idx_d = bit_idx_q;
    byte_d    = byte_q;
    stop_smp  = 1'b0;
    unique case (state_q)
      UART_RX_IDLE: begin
        if (!rx_s) begin
          bit_ctr_d = HALF;
          state_d   = UART_RX_START;
        end
      end
      UART_RX_START: begin
        if (!ctr_zero) begin
          bit_ctr_d = bit_ctr_q - bctr_t'(1);
        end else if (!rx_s) begin
          bit_ctr_d = FULL;
          bit_idx_d = '0;
          state_d   = UART_RX_DATA;
        end else begin
          state_d = UART_RX_IDLE;
        end
      end
      UART_RX_DATA: begin
        if (!ctr_zero) begin
          bit_ctr_d = bit_ctr_q - bctr_t'(1);
        end else begin
          byte_d    = {rx_s, byte_q[7:1]};
          bit_ctr_d = FULL;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = UART_RX_STOP;
          end
        end
      end
      UART_RX_STOP: begin
        // Leave mid stop bit so back-to-back frames tolerate baud skew.
        if (!ctr_zero) begin
          bit_ctr_d = bit_ctr_q - bctr_t'(1);
        end else begin
          stop_smp = 1'b1;
          state_d  = UART_RX_IDLE;
        end
      end
      default: state_d = UART_RX_IDLE;
    endcase
  end

  assign pop  = valid_q && i_rd && (i_ctr == 2'd3);
  assign word = {byte_q, lo_q};

  always_comb begin
    lo_d      = lo_q;
    hi_d      = hi_q;
    buf_d     = buf_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    ovr_d     = 1'b0;
    word_done = 1'b0;
    if (stop_smp) begin
      if (!rx_s) begin
        err_d = 1'b1;
        hi_d  = 1'b0;
      end else if (!hi_q) begin
        lo_d = byte_q;
        hi_d = 1'b1;
      end else begin
        hi_d      = 1'b0;
        word_done = 1'b1;
      end
    end
    if (word_done) begin
      if (!valid_q || pop) begin
        buf_d   = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= UART_RX_IDLE;
      bit_ctr_q <= '0;
      bit_idx_q <= '0;
      byte_q    <= '0;
      lo_q      <= '0;
      hi_q      <= 1'b0;
      buf_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_ctr_q <= bit_ctr_d;
      bit_idx_q <= bit_idx_d;
      byte_q    <= byte_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      buf_q     <= buf_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_valid   = valid_q;
  assign o_slice   = valid_q ? slice_sel(buf_q, i_ctr) : '0;
  assign o_err     = err_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_idli_uart_rx_m.sv
// Bench for idli_uart_rx_m: frame-level model plus directed scenarios.
// The model works on whole frames scheduled by their stop-sample cycle.
module tb_idli_uart_rx_m;
  import idli_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   rx = 1'b1;
  logic   rd = 1'b0;
  ctr_t   ctr = '0;
  logic   valid;
  slice_t slice;
  logic   err;
  logic   ovr;

  idli_uart_rx_m #(
    .CLKS_PER_BIT (16)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_uart_rx (rx),
    .i_ctr     (ctr),
    .i_rd      (rd),
    .o_valid   (valid),
    .o_slice   (slice),
    .o_err     (err),
    .o_overrun (ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rd_start = -100;
  int tests = 0;
  int fails = 0;

  bit [8:0] ev [int];

  bit         mv, mhi, merr, movr;
  logic [7:0] mlo;
  data_t      mbuf;

  int  err_cnt = 0;
  int  ovr_cnt = 0;
  int  fall_cnt = 0;
  int  rise_cyc = -1;
  bit  vprev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock step; inputs change 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    ctr = ctr_t'(cyc);
    rd  = (cyc >= rd_start) && (cyc < rd_start + 4);
  endtask

  // Frame starting this cycle is stop-sampled 154 cycles later:
  // 2 sync + 8 half bit + 9 full bits.
  task automatic send_byte(input logic [7:0] b, input bit ok);
    ev[cyc + 154] = {ok, b};
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) tick();
    end
    rx = ok;
    repeat (16) tick();
    rx = 1'b1;
  endtask

  task automatic align(input int m);
    while (cyc % 4 != m) tick();
  endtask

  task automatic read_word(input string name, input data_t exp);
    slice_t got [4];
    align(3);
    rd_start = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      got[i] = slice;
    end
    tick();
    check({name, "_word"}, {got[3], got[2], got[1], got[0]}, exp);
    check({name, "_empty"}, valid, 1'b0);
  endtask

  always @(negedge clk) begin
    slice_t     es;
    bit         pop, done, nerr, novr;
    logic [7:0] b;
    bit         ok;
    data_t      w;
    if (!rst_n) begin
      mv = 0; mhi = 0; merr = 0; movr = 0;
      mlo = '0; mbuf = '0; vprev = 0;
    end else begin
      es = mv ? mbuf[4*ctr +: 4] : 4'h0;
      tests++;
      if ({valid, slice, err, ovr} !== {mv, es, merr, movr}) begin
        fails++;
        $display("FAIL cycle %0d: v/s/e/o got %b/%h/%b/%b expected %b/%h/%b/%b",
                 cyc, valid, slice, err, ovr, mv, es, merr, movr);
      end
      if (err) err_cnt++;
      if (ovr) ovr_cnt++;
      if (valid && !vprev) rise_cyc = cyc;
      if (!valid && vprev) fall_cnt++;
      vprev = valid;
      pop  = mv && rd && (ctr == 2'd3);
      done = 0; nerr = 0; novr = 0;
      w    = '0;
      if (ev.exists(cyc)) begin
        b  = ev[cyc][7:0];
        ok = ev[cyc][8];
        if (!ok) begin
          nerr = 1; mhi = 0;
        end else if (!mhi) begin
          mlo = b; mhi = 1;
        end else begin
          w = {b, mlo}; mhi = 0; done = 1;
        end
      end
      if (done) begin
        if (!mv || pop) begin
          mbuf = w; mv = 1;
        end else begin
          novr = 1;
        end
      end else if (pop) begin
        mv = 0;
      end
      merr = nerr;
      movr = novr;
    end
  end

  initial begin
    int kh, k1, k2, fc;
    #1;
    check("rst_valid", valid, 1'b0);
    check("rst_slice", slice, 4'h0);
    check("rst_err", err, 1'b0);
    check("rst_ovr", ovr, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    send_byte(8'h34, 1);
    kh = cyc;
    send_byte(8'h12, 1);
    check("basic_rise", rise_cyc, kh + 155);
    read_word("basic", 16'h1234);

    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    check("glitch_noerr", err_cnt, 0);
    check("glitch_novalid", valid, 1'b0);
    send_byte(8'hAA, 1);
    send_byte(8'h55, 1);
    read_word("glitch", 16'h55AA);

    send_byte(8'h34, 0);
    repeat (20) tick();
    check("frame_err_cnt", err_cnt, 1);
    send_byte(8'h78, 1);
    send_byte(8'h56, 1);
    read_word("frame", 16'h5678);

    send_byte(8'h01, 1);
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_byte(8'h00, 1);
    check("ovr_cnt", ovr_cnt, 1);
    read_word("ovr", 16'h0001);

    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    align(1);
    fc = fall_cnt;
    k1 = cyc;
    k2 = k1 + 160;
    rd_start = k2 + 154 - 3;
    send_byte(8'h44, 1);
    send_byte(8'h33, 1);
    check("popload_valid", valid, 1'b1);
    check("popload_nofall", fall_cnt, fc);
    check("popload_novr", ovr_cnt, 1);
    read_word("popload", 16'h3344);

    send_byte(8'h66, 1);
    send_byte(8'h77, 1);
    check("prereset_valid", valid, 1'b1);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'hE5 >> i);
      repeat (16) tick();
    end
    rx = 1'b0;
    repeat (8) tick();
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("midrst_valid", valid, 1'b0);
    check("midrst_slice", slice, 4'h0);
    check("midrst_err", err, 1'b0);
    check("midrst_ovr", ovr, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    send_byte(8'hCD, 1);
    send_byte(8'hAB, 1);
    read_word("postrst", 16'hABCD);
    check("total_err", err_cnt, 1);
    check("total_ovr", ovr_cnt, 1);

    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
